// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file:
//   - default parameter constants for regfile_mp
//   - clear FSM state enum
//   - write-port priority helper (highest port index wins)
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int RF_DATA_W_DEF  = 32;
  localparam int RF_DEPTH_DEF   = 32;
  localparam int RF_NUM_RD_DEF  = 2;
  localparam int RF_NUM_WR_DEF  = 1;
  localparam int RF_ZERO_REG_DEF = 1;

  // Upper bound on write ports; the priority helper works on a mask this wide.
  localparam int RF_MAX_WR = 4;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  typedef logic [RF_MAX_WR-1:0] rf_wr_mask_t;
  typedef logic [1:0]           rf_wr_port_t;

  // Returns the index of the highest set bit of a write-hit mask. The caller
  // only uses the result when at least one bit is set.
  function automatic rf_wr_port_t rf_winner(input rf_wr_mask_t hits);
    rf_wr_port_t w;
    w = '0;
    for (int i = 0; i < RF_MAX_WR; i++) begin
      if (hits[i]) w = rf_wr_port_t'(i);
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// -----------------------------------------------------------------------------
// regfile_clear_fsm
// Sequential clear engine for regfile_mp. Walks the array one entry per cycle
// and tells the top which entry to zero.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clear_req      level request, sampled only while idle
//   busy           clear in progress (state register decode)
//   wr_ready       !busy, normal writes allowed
//   clear_done     one-cycle pulse the cycle after the last entry is zeroed
//   clear_strobe   zero the entry at clear_idx on this edge
//   clear_idx      entry being zeroed this cycle
// -----------------------------------------------------------------------------
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter  int DEPTH = RF_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_req,
  output logic          busy,
  output logic          wr_ready,
  output logic          clear_done,
  output logic          clear_strobe,
  output logic [AW-1:0] clear_idx
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          last_entry;

  assign last_entry = (cnt_q == AW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Requests arriving while a clear runs are simply not looked at, so there
  // is no restart and nothing is queued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      RF_IDLE: begin
        if (clear_req) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end
      end
      RF_CLEAR: begin
        if (last_entry) begin
          state_d = RF_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  // All outputs decode registers only, so busy/wr_ready are glitch-free.
  always_comb begin
    busy         = (state_q == RF_CLEAR);
    wr_ready     = (state_q != RF_CLEAR);
    clear_strobe = (state_q == RF_CLEAR);
    clear_idx    = cnt_q;
    clear_done   = done_q;
  end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port register file with asynchronous array reset,
// optional hardwired-zero entry 0, highest-index-wins write priority and a
// sequential clear engine (regfile_clear_fsm).
// Parameters: DATA_W, DEPTH (power of two), NUM_RD, NUM_WR (1..4), ZERO_REG.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   rd_addr      NUM_RD read addresses; rd_data combinational read data
//   wr_en/wr_addr/wr_data  NUM_WR write ports, committed when wr_ready
//   wr_ready     low while clearing; writes then are discarded
//   clear_req    start a sequential clear; busy while running
//   clear_done   one-cycle completion pulse
// Build option: define REGFILE_BYPASS_EN to forward accepted same-cycle write
// data to matching read ports.
// -----------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = RF_DATA_W_DEF,
  parameter  int DEPTH    = RF_DEPTH_DEF,
  parameter  int NUM_RD   = RF_NUM_RD_DEF,
  parameter  int NUM_WR   = RF_NUM_WR_DEF,
  parameter  int ZERO_REG = RF_ZERO_REG_DEF,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]      wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
  output logic                           wr_ready,
  input  logic                           clear_req,
  output logic                           busy,
  output logic                           clear_done
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clear_strobe;
  logic [AW-1:0]     clear_idx;
  logic [NUM_WR-1:0] wr_accept;
  logic [DEPTH-1:0]  ent_we;
  logic [DATA_W-1:0] ent_wdata [DEPTH];

  regfile_clear_fsm #(
    .DEPTH (DEPTH)
  ) u_clear_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_req    (clear_req),
    .busy         (busy),
    .wr_ready     (wr_ready),
    .clear_done   (clear_done),
    .clear_strobe (clear_strobe),
    .clear_idx    (clear_idx)
  );

  // Which accepted write ports target address a.
  function automatic rf_wr_mask_t hit_mask(
    input logic [AW-1:0]             a,
    input logic [NUM_WR-1:0]         acc,
    input logic [NUM_WR-1:0][AW-1:0] addrs
  );
    rf_wr_mask_t m;
    m = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      m[i] = acc[i] && (addrs[i] == a);
    end
    return m;
  endfunction

  // Data of the given write port, selected without indexing past NUM_WR.
  function automatic logic [DATA_W-1:0] pick_data(
    input rf_wr_port_t                   w,
    input logic [NUM_WR-1:0][DATA_W-1:0] data
  );
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (rf_wr_port_t'(i) == w) d = data[i];
    end
    return d;
  endfunction

  assign wr_accept = wr_en & {NUM_WR{wr_ready}};

  // Per-entry write enable and winning data. Entry 0 is never written when
  // it is hardwired, so its storage stays at the reset value.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      rf_wr_mask_t hits;
      hits         = hit_mask(AW'(e), wr_accept, wr_addr);
      ent_we[e]    = (|hits) && !((ZERO_REG != 0) && (e == 0));
      ent_wdata[e] = pick_data(rf_winner(hits), wr_data);
    end
  end

  // No port writes are accepted while clearing, so the clear write never
  // competes with a port write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else if (clear_strobe) begin
      mem[clear_idx] <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (ent_we[e]) mem[e] <= ent_wdata[e];
      end
    end
  end

  // Forwarding relies on wr_accept, which is already zero during a clear.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data[p] = mem[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      begin
        rf_wr_mask_t byp;
        byp = hit_mask(rd_addr[p], wr_accept, wr_addr);
        if (|byp) rd_data[p] = pick_data(rf_winner(byp), wr_data);
      end
`endif
      if ((ZERO_REG != 0) && (rd_addr[p] == '0)) rd_data[p] = '0;
    end
  end

endmodule
